// File: rtl/viterbi_step_sequencer.sv
// Step sequencer for the HMM-Viterbi datapath: turns clk_div rises into one-cycle step strobes
// over a frame of NSTEPS steps. Define STEP_WDOG_EN to add the clk_div watchdog and sticky timeout.
module viterbi_step_sequencer #(
    parameter int NSTEPS   = 16,
    parameter int SWIDTH   = 8,
    parameter int WDOG_MAX = 1023,
    parameter int WWIDTH   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_div,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              step_en,
    output logic [SWIDTH-1:0] step_idx,
    output logic              first_step,
    output logic              last_step,
    output logic              done,
    output logic              timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SWIDTH-1:0] LAST_IDX = SWIDTH'(NSTEPS - 1);

    logic [1:0]        state_q, state_d;
    logic [SWIDTH-1:0] cnt_q, cnt_d;
    logic              clk_div_q;
    logic              rise;
    logic              busy_q, busy_d;
    logic              step_en_q, step_en_d;
    logic [SWIDTH-1:0] step_idx_q, step_idx_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

`ifdef STEP_WDOG_EN
    localparam logic [WWIDTH-1:0] WDOG_LIM = WWIDTH'(WDOG_MAX - 1);

    logic [WWIDTH-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
`endif

    assign rise = clk_div & ~clk_div_q;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_en_d  = 1'b0;
        step_idx_d = step_idx_q;
        first_d    = 1'b0;
        last_d     = 1'b0;
        done_d     = (state_q == S_DONE);
`ifdef STEP_WDOG_EN
        wdog_d     = wdog_q;
        timeout_d  = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A rise coinciding with start is dropped: the first step waits a full clk_div period.
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
`ifdef STEP_WDOG_EN
                    wdog_d    = '0;
                    timeout_d = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    step_en_d  = 1'b1;
                    step_idx_d = cnt_q;
                    first_d    = (cnt_q == '0);
                    last_d     = (cnt_q == LAST_IDX);
`ifdef STEP_WDOG_EN
                    wdog_d     = '0;
`endif
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + SWIDTH'(1);
                    end
                end
`ifdef STEP_WDOG_EN
                // Fires after WDOG_MAX consecutive rise-free RUN cycles.
                else if (wdog_q == WDOG_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    wdog_d = wdog_q + WWIDTH'(1);
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // busy stays up through the final strobe and drops together with done.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            // NOTE: resetting the edge register high keeps a clk_div already high at release from looking like a rise.
            clk_div_q  <= 1'b1;
            busy_q     <= 1'b0;
            step_en_q  <= 1'b0;
            step_idx_q <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_div_q  <= clk_div;
            busy_q     <= busy_d;
            step_en_q  <= step_en_d;
            step_idx_q <= step_idx_d;
            first_q    <= first_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

`ifdef STEP_WDOG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy       = busy_q;
    assign step_en    = step_en_q;
    assign step_idx   = step_idx_q;
    assign first_step = first_q;
    assign last_step  = last_q;
    assign done       = done_q;

endmodule
